usb_serial_in_ep: RTL and testbench



---
 rtl/usb_ep_pkg.sv | 28 ++
 rtl/usb_byte_fifo.sv | 62 ++++++
 rtl/usb_serial_in_ep.sv | 163 ++++++++++++++++
 tb/tb_usb_serial_in_ep.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared types and defaults for the USB IN endpoint client.
package usb_ep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DONE,
        ST_WAIT_ACK
    } ep_state_t;

    localparam int unsigned DEF_MAX_PKT       = 32;
    localparam int unsigned DEF_FIFO_DEPTH    = 16;
    localparam int unsigned DEF_FLUSH_TIMEOUT = 480;

    // Ceiling log2, usable in constant expressions; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// Synchronous byte FIFO with combinational head data and occupancy count.
module usb_byte_fifo
    import usb_ep_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign level     = count;
    assign head_data = mem[rd_ptr];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    // Storage array; no reset needed since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count tracks occupancy, unchanged on push+pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usb_serial_in_ep.sv
// IN endpoint client: buffers a user byte stream and packetises it into
// IN packets of up to MAX_PKT bytes, with idle-timeout flush and ZLP handling.
module usb_serial_in_ep
    import usb_ep_pkg::*;
#(
    parameter int unsigned MAX_PKT       = DEF_MAX_PKT,
    parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int unsigned FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       stall_cfg,
    output logic                       ep_req,
    input  logic                       ep_grant,
    input  logic                       ep_data_free,
    output logic                       ep_data_put,
    output logic [7:0]                 ep_data,
    output logic                       ep_data_done,
    output logic                       ep_stall,
    input  logic                       ep_acked,
    output logic [clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned CW = clog2(MAX_PKT) + 1;
    localparam int unsigned TW = clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [CW-1:0] PKT_FULL = CW'(MAX_PKT);
    localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);

    ep_state_t     state;
    ep_state_t     state_d;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] pkt_cnt_d;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_inc;
    logic          zlp_pend;
    logic          zlp_pend_d;
    logic          stall_q;
    logic          put;
    logic          fifo_full;
    logic          fifo_empty;

    usb_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (put),
        .head_data (ep_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready    = ~fifo_full;
    assign ep_stall    = stall_q;
    assign ep_data_put = put;
    assign timer_inc   = (timer == '1) ? timer : timer + 1'b1;

    // Halt request is registered once before it reaches the engine and the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_cfg;
        end
    end

    // State register plus packet byte count, idle timer and pending-ZLP flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pkt_cnt  <= '0;
            timer    <= '0;
            zlp_pend <= 1'b0;
        end else begin
            state    <= state_d;
            pkt_cnt  <= pkt_cnt_d;
            timer    <= timer_d;
            zlp_pend <= zlp_pend_d;
        end
    end

    // Next-state and engine-interface outputs.
    always_comb begin
        state_d      = state;
        pkt_cnt_d    = pkt_cnt;
        timer_d      = timer;
        zlp_pend_d   = zlp_pend;
        ep_req       = 1'b0;
        put          = 1'b0;
        ep_data_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!stall_q) begin
                    if (!fifo_empty) begin
                        // Fresh data cancels any pending ZLP; it goes out as payload.
                        zlp_pend_d = 1'b0;
                        timer_d    = '0;
                        state_d    = ST_REQ;
                    end else if (zlp_pend) begin
                        // ZLP window: only sent if the FIFO stays empty for the timeout.
                        if (timer >= TMO_LAST) begin
                            state_d = ST_REQ;
                        end else begin
                            timer_d = timer_inc;
                        end
                    end
                end
            end
            ST_REQ: begin
                ep_req = 1'b1;
                if (ep_grant) begin
                    pkt_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                ep_req = 1'b1;
                put    = ep_grant & ep_data_free & ~fifo_empty &
                         (pkt_cnt < PKT_FULL) & ~zlp_pend;
                if (put) begin
                    pkt_cnt_d = pkt_cnt + 1'b1;
                    timer_d   = '0;
                end
                if (pkt_cnt == PKT_FULL) begin
                    zlp_pend_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (zlp_pend) begin
                    state_d = ST_DONE;
                end else if (!put) begin
                    // Timer runs on every cycle without a put, including grant loss.
                    timer_d = timer_inc;
                    if (fifo_empty && (pkt_cnt != '0) && (timer >= TMO_LAST)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                ep_data_done = 1'b1;
                state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ep_acked) begin
                    // A ZLP stays pending only after a full packet that drained the FIFO.
                    zlp_pend_d = (pkt_cnt == PKT_FULL) && fifo_empty;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_serial_in_ep.sv
// Self-checking bench for usb_serial_in_ep: scenario tasks plus a randomized
// stream checked against a packet-splitting reference model.
module tb_usb_serial_in_ep;

    localparam int MAX_PKT    = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int FT         = 480;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       stall_cfg;
    logic       ep_req;
    logic       ep_grant;
    logic       ep_data_free;
    logic       ep_data_put;
    logic [7:0] ep_data;
    logic       ep_data_done;
    logic       ep_stall;
    logic       ep_acked;
    logic [4:0] fifo_level;

    int compared   = 0;
    int mismatched = 0;

    // Observation log, one entry per sampled cycle / event.
    int         cyc = 0;
    logic [7:0] put_q[$];
    int         put_cyc[$];
    int         done_cyc[$];
    int         done_puts[$];
    logic       req_hist[$];
    int         overlap = 0;

    always #5 clk = ~clk;

    usb_serial_in_ep #(
        .MAX_PKT       (MAX_PKT),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall_cfg    (stall_cfg),
        .ep_req       (ep_req),
        .ep_grant     (ep_grant),
        .ep_data_free (ep_data_free),
        .ep_data_put  (ep_data_put),
        .ep_data      (ep_data),
        .ep_data_done (ep_data_done),
        .ep_stall     (ep_stall),
        .ep_acked     (ep_acked),
        .fifo_level   (fifo_level)
    );

    always @(negedge clk) begin
        req_hist.push_back(ep_req);
        if (ep_data_put) begin
            put_q.push_back(ep_data);
            put_cyc.push_back(cyc);
        end
        if (ep_data_done) begin
            done_cyc.push_back(cyc);
            done_puts.push_back(put_q.size());
        end
        if (ep_data_put && ep_data_done) overlap++;
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL push_wait in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cyc.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_ack();
        @(posedge clk);
        #1;
        ep_acked = 1'b1;
        @(posedge clk);
        #1;
        ep_acked = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_data = '0; in_valid = 1'b0; stall_cfg = 1'b0;
        ep_grant = 1'b0; ep_data_free = 1'b0; ep_acked = 1'b0;
        repeat (3) @(negedge clk);
        compared += 6;
        if (ep_req !== 1'b0) begin mismatched++; $display("FAIL rst_req got=%0b exp=0", ep_req); end
        if (ep_data_put !== 1'b0) begin mismatched++; $display("FAIL rst_put got=%0b exp=0", ep_data_put); end
        if (ep_data_done !== 1'b0) begin mismatched++; $display("FAIL rst_done got=%0b exp=0", ep_data_done); end
        if (ep_stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall got=%0b exp=0", ep_stall); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        if (fifo_level !== 5'd0) begin mismatched++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_short();
        logic [7:0] bytes[3] = '{8'hA1, 8'hA2, 8'hA3};
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int e0;
        int bad = 0;
        bit ok;
        ep_grant = 1'b1; ep_data_free = 1'b1;
        in_valid = 1'b1; in_data = bytes[0];
        @(posedge clk);
        #1;
        e0 = cyc;                      // index of the first cycle after the push edge
        in_data = bytes[1]; tick(1);
        in_data = bytes[2]; tick(1);
        in_valid = 1'b0;
        wait_dones(base_d + 1, FT + 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL short_done got=timeout exp=done"); end
        compared += 2;
        if (req_hist[e0] !== 1'b0 || req_hist[e0+1] !== 1'b1) begin
            mismatched++;
            $display("FAIL short_req_latency got=%0b%0b exp=01", req_hist[e0], req_hist[e0+1]);
        end
        if (put_q.size() - base_p != 3) begin
            mismatched++;
            $display("FAIL short_put_count got=%0d exp=3", put_q.size() - base_p);
        end
        if (ok && put_q.size() - base_p == 3) begin
            for (int i = 0; i < 3; i++) begin
                if (put_q[base_p+i] !== bytes[i] || put_cyc[base_p+i] != e0 + 2 + i) bad++;
            end
            compared += 2;
            if (bad != 0) begin
                mismatched++;
                $display("FAIL short_put_data got=%h,%h,%h@%0d exp=a1,a2,a3@%0d", put_q[base_p],
                         put_q[base_p+1], put_q[base_p+2], put_cyc[base_p], e0 + 2);
            end
            // Done is entered FT edges after the edge that commits the last byte.
            if (done_cyc[base_d] != put_cyc[base_p+2] + FT + 1) begin
                mismatched++;
                $display("FAIL short_flush_time got=%0d exp=%0d", done_cyc[base_d] - put_cyc[base_p+2],
                         FT + 1);
            end
        end
        send_ack();
        tick(FT + 20);
        compared++;
        if (done_cyc.size() != base_d + 1) begin
            mismatched++;
            $display("FAIL short_no_zlp got=%0d exp=%0d", done_cyc.size(), base_d + 1);
        end
    endtask

    task automatic test_full(input bit with_data);
        logic [7:0] exp_b[$];
        logic [7:0] b;
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int a;
        int bad = 0;
        bit ok;
        ep_grant = 1'b1; ep_data_free = 1'b1;
        for (int i = 0; i < MAX_PKT; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            push_byte(b);
        end
        wait_dones(base_d + 1, 1000, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL full_done got=timeout exp=done"); end
        if (ok) begin
            compared++;
            if (done_puts[base_d] - base_p != MAX_PKT) begin
                mismatched++;
                $display("FAIL full_put_count got=%0d exp=%0d", done_puts[base_d] - base_p, MAX_PKT);
            end else begin
                for (int i = 0; i < MAX_PKT; i++) if (put_q[base_p+i] !== exp_b[i]) bad++;
                compared += 2;
                if (bad != 0) begin mismatched++; $display("FAIL full_data got=%0d_bad exp=0_bad", bad); end
                if (done_cyc[base_d] != put_cyc[base_p+MAX_PKT-1] + 2) begin
                    mismatched++;
                    $display("FAIL full_done_gap got=%0d exp=2",
                             done_cyc[base_d] - put_cyc[base_p+MAX_PKT-1]);
                end
            end
        end
        send_ack();
        a = cyc;
        if (!with_data) begin
            wait_dones(base_d + 2, FT + 100, ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL zlp_done got=timeout exp=done"); end
            if (ok) begin
                compared += 2;
                if (done_puts[base_d+1] != done_puts[base_d]) begin
                    mismatched++;
                    $display("FAIL zlp_len got=%0d exp=0", done_puts[base_d+1] - done_puts[base_d]);
                end
                // FT idle cycles in IDLE, then REQ, FILL, DONE.
                if (done_cyc[base_d+1] != a + FT + 2) begin
                    mismatched++;
                    $display("FAIL zlp_time got=%0d exp=%0d", done_cyc[base_d+1] - a, FT + 2);
                end
            end
            send_ack();
        end else begin
            tick(10);
            push_byte(8'h55);
            wait_dones(base_d + 2, FT + 100, ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL cancel_done got=timeout exp=done"); end
            if (ok) begin
                compared++;
                if (done_puts[base_d+1] - done_puts[base_d] != 1 || put_q[put_q.size()-1] !== 8'h55) begin
                    mismatched++;
                    $display("FAIL cancel_pkt got=%0d_bytes/%h exp=1_bytes/55",
                             done_puts[base_d+1] - done_puts[base_d], put_q[put_q.size()-1]);
                end
            end
            send_ack();
            tick(FT + 20);
            compared++;
            if (done_cyc.size() != base_d + 2) begin
                mismatched++;
                $display("FAIL cancel_no_zlp got=%0d exp=%0d", done_cyc.size() - base_d, 2);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[$];
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int acc = 0;
        int bad = 0;
        bit ok;
        ep_grant = 1'b1; ep_data_free = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                exp_b.push_back(in_data);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        compared += 4;
        if (acc != FIFO_DEPTH) begin mismatched++; $display("FAIL bp_accepted got=%0d exp=%0d", acc, FIFO_DEPTH); end
        if (fifo_level !== 5'(FIFO_DEPTH)) begin mismatched++; $display("FAIL bp_level got=%0d exp=%0d", fifo_level, FIFO_DEPTH); end
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        if (put_q.size() != base_p) begin mismatched++; $display("FAIL bp_no_put got=%0d exp=0", put_q.size() - base_p); end
        @(posedge clk);
        #1;
        ep_data_free = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fifo_level !== 5'(FIFO_DEPTH - i)) bad++;
        end
        compared++;
        if (bad != 0) begin mismatched++; $display("FAIL bp_drain got=%0d_bad exp=0_bad", bad); end
        wait_dones(base_d + 1, FT + 200, ok);
        compared++;
        if (!ok || done_puts[base_d] - base_p != exp_b.size()) begin
            mismatched++;
            $display("FAIL bp_packet got=%0d_bytes exp=%0d_bytes", put_q.size() - base_p, exp_b.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_b.size(); i++) if (put_q[base_p+i] !== exp_b[i]) bad++;
            compared++;
            if (bad != 0) begin mismatched++; $display("FAIL bp_data got=%0d_bad exp=0_bad", bad); end
        end
        send_ack();
    endtask

    task automatic test_grant_loss();
        logic [7:0] exp_b[$];
        logic [7:0] b;
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int bad = 0;
        int n = 0;
        bit ok;
        ep_grant = 1'b1; ep_data_free = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            push_byte(b);
        end
        ep_data_free = 1'b1;
        while (put_q.size() - base_p < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        ep_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ep_data_put !== 1'b0 || ep_req !== 1'b1) bad++;
        end
        #1;
        compared += 2;
        if (bad != 0) begin mismatched++; $display("FAIL gl_hold got=%0d_bad exp=0_bad", bad); end
        if (put_q.size() - base_p != 3) begin
            mismatched++;
            $display("FAIL gl_put_before got=%0d exp=3", put_q.size() - base_p);
        end
        @(posedge clk);
        #1;
        ep_grant = 1'b1;
        wait_dones(base_d + 1, FT + 200, ok);
        compared++;
        if (!ok || done_puts[base_d] - base_p != 10) begin
            mismatched++;
            $display("FAIL gl_packet got=%0d_bytes exp=10_bytes", put_q.size() - base_p);
        end else begin
            bad = 0;
            for (int i = 0; i < 10; i++) if (put_q[base_p+i] !== exp_b[i]) bad++;
            compared++;
            if (bad != 0) begin mismatched++; $display("FAIL gl_order got=%0d_bad exp=0_bad", bad); end
        end
        send_ack();
    endtask

    task automatic test_stall();
        logic [7:0] exp_b[$];
        logic [7:0] b;
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int bad = 0;
        bit ok;
        ep_grant = 1'b1; ep_data_free = 1'b1;
        stall_cfg = 1'b1;
        @(negedge clk);
        compared++;
        if (ep_stall !== 1'b0) begin mismatched++; $display("FAIL stall_latency got=%0b exp=0", ep_stall); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_b.push_back(b);
            push_byte(b);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ep_req !== 1'b0 || ep_data_put !== 1'b0 || ep_stall !== 1'b1) bad++;
        end
        compared += 2;
        if (bad != 0) begin mismatched++; $display("FAIL stall_hold got=%0d_bad exp=0_bad", bad); end
        if (fifo_level !== 5'd4) begin mismatched++; $display("FAIL stall_level got=%0d exp=4", fifo_level); end
        @(posedge clk);
        #1;
        stall_cfg = 1'b0;
        wait_dones(base_d + 1, FT + 200, ok);
        compared++;
        if (!ok || done_puts[base_d] - base_p != 4) begin
            mismatched++;
            $display("FAIL stall_resume got=%0d_bytes exp=4_bytes", put_q.size() - base_p);
        end else begin
            bad = 0;
            for (int i = 0; i < 4; i++) if (put_q[base_p+i] !== exp_b[i]) bad++;
            compared++;
            if (bad != 0) begin mismatched++; $display("FAIL stall_data got=%0d_bad exp=0_bad", bad); end
        end
        send_ack();
    endtask

    task automatic test_random();
        logic [7:0] exp_b[$];
        int exp_len[$];
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int n;
        int bad = 0;
        bit stop = 1'b0;
        ep_grant = 1'b1; ep_data_free = 1'b1;
        n = ($urandom_range(0, 1) != 0) ? MAX_PKT * $urandom_range(1, 3) : $urandom_range(1, 100);
        for (int i = 0; i < n; i++) exp_b.push_back(8'($urandom));
        // Reference: full packets, then the remainder, or a ZLP if nothing remains.
        for (int i = 0; i < n / MAX_PKT; i++) exp_len.push_back(MAX_PKT);
        exp_len.push_back(n % MAX_PKT);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    push_byte(exp_b[i]);
                    tick($urandom_range(0, 3));
                end
            end
            begin
                bit ok;
                for (int k = 0; k < exp_len.size(); k++) begin
                    wait_dones(base_d + k + 1, 3000, ok);
                    if (!ok) break;
                    tick($urandom_range(0, 4));
                    send_ack();
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    ep_data_free = ($urandom_range(0, 3) != 0);
                end
                ep_data_free = 1'b1;
            end
        join
        compared++;
        if (done_cyc.size() - base_d != exp_len.size()) begin
            mismatched++;
            $display("FAIL rand_packets got=%0d exp=%0d n=%0d", done_cyc.size() - base_d, exp_len.size(), n);
        end else begin
            for (int k = 0; k < exp_len.size(); k++) begin
                if (done_puts[base_d+k] - (k == 0 ? base_p : done_puts[base_d+k-1]) != exp_len[k]) bad++;
            end
            for (int i = 0; i < n; i++) if (put_q[base_p+i] !== exp_b[i]) bad++;
            compared++;
            if (bad != 0) begin mismatched++; $display("FAIL rand_stream got=%0d_bad exp=0_bad n=%0d", bad, n); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int base_p = put_q.size();
        int base_d = done_cyc.size();
        int n = 0;
        ep_grant = 1'b1; ep_data_free = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(8'($urandom));
        ep_data_free = 1'b1;
        while (put_q.size() - base_p < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        #1;
        compared += 4;
        if (ep_req !== 1'b0) begin mismatched++; $display("FAIL midrst_req got=%0b exp=0", ep_req); end
        if (ep_data_put !== 1'b0) begin mismatched++; $display("FAIL midrst_put got=%0b exp=0", ep_data_put); end
        if (fifo_level !== 5'd0) begin mismatched++; $display("FAIL midrst_level got=%0d exp=0", fifo_level); end
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
        tick(2);
        reset = 1'b0;
        tick(FT + 50);
        compared++;
        if (done_cyc.size() != base_d || ep_req !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_no_done got=%0d_dones/req=%0b exp=0_dones/req=0",
                     done_cyc.size() - base_d, ep_req);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_short();
        test_full(1'b0);
        test_full(1'b1);
        test_backpressure();
        test_grant_loss();
        test_stall();
        test_random();
        test_random();
        test_reset_mid_fill();
        compared++;
        if (overlap != 0) begin mismatched++; $display("FAIL done_put_overlap got=%0d exp=0", overlap); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
